// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter: fixed-priority or descending round-robin winner search,
// grant held while the owner keeps requesting, optional hold limit forcing rotation in RR mode.
module rr_priority_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             rr_mode,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             none
);

  localparam int HC_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int HC_SAT_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : ((1 << HC_W) - 1);
  localparam logic [HC_W-1:0] HC_SAT = HC_SAT_I[HC_W-1:0];
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] cur, cur_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [HC_W-1:0]  hold_cnt, hold_cnt_n;
  logic [N-1:0]     others;
  logic [N-1:0]     srch_req;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             limit_hit;
  logic [N-1:0]     gnt_n;
  logic             none_n;

  // Later loop iterations overwrite earlier hits, so the last hit is the highest-priority one.
  function automatic logic [IDX_W:0] find_winner(input logic [N-1:0] r, input logic rr,
                                                 input logic [IDX_W-1:0] p);
    logic [IDX_W:0] res;
    int j;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rr) begin
        j = int'(p) - k;
        if (j < 0) j = j + N;
      end else begin
        j = N - 1 - k;
      end
      if (r[j]) res = {1'b1, IDX_W'(j)};
    end
    return res;
  endfunction

  always_comb begin
    others      = req;
    others[cur] = 1'b0;
    // While granting, the owner is only re-searched for when it has dropped or is being rotated out.
    srch_req    = (state == GRANT) ? others : req;
    {win_found, win_idx} = find_winner(srch_req, rr_mode, ptr);
    limit_hit   = rr_mode && (MAX_HOLD != 0) && (hold_cnt == HC_SAT) && (others != '0);

    state_n    = state;
    cur_n      = cur;
    ptr_n      = ptr;
    hold_cnt_n = hold_cnt;

    if (!enable) begin
      state_n = IDLE;
    end else if (state == GRANT && req[cur] && !limit_hit) begin
      hold_cnt_n = (hold_cnt == HC_SAT) ? hold_cnt : hold_cnt + 1'b1;
    end else if (win_found) begin
      state_n    = GRANT;
      cur_n      = win_idx;
      hold_cnt_n = '0;
      if (rr_mode) ptr_n = (win_idx == '0) ? PTR_RST : win_idx - 1'b1;
    end else begin
      state_n = IDLE;
    end

    gnt_n = '0;
    if (state_n == GRANT) gnt_n[cur_n] = 1'b1;
    none_n = enable && (req == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      ptr       <= PTR_RST;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      none      <= 1'b0;
    end else begin
      state     <= state_n;
      cur       <= cur_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_cnt_n;
      gnt       <= gnt_n;
      gnt_idx   <= (state_n == GRANT) ? cur_n : '0;
      gnt_valid <= (state_n == GRANT);
      none      <= none_n;
    end
  end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Bench for rr_priority_arbiter (N=4, MAX_HOLD=3): directed scenarios followed by random
// traffic, all checked against an ownership/priority-list reference model.
module tb_rr_priority_arbiter;

  localparam int N        = 4;
  localparam int IDX_W    = 2;
  localparam int MAX_HOLD = 3;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             rr_mode;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             none;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the resource, for how many consecutive cycles, and where RR resumes.
  int m_owner  = -1;
  int m_ptr    = N - 1;
  int m_cycles = 0;
  bit m_none   = 0;

  rr_priority_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rr_mode(rr_mode), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .none(none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
  endtask

  function automatic int pick(input logic [N-1:0] r, input logic rr, input int p);
    int i;
    if (!rr) begin
      for (int b = N - 1; b >= 0; b--) if (r[b]) return b;
    end else begin
      for (int k = 0; k < N; k++) begin
        i = (p - k + N) % N;
        if (r[i]) return i;
      end
    end
    return -1;
  endfunction

  function automatic void model_edge();
    logic [N-1:0] cand;
    int w;
    if (!rst_n) begin
      m_owner = -1; m_ptr = N - 1; m_cycles = 0; m_none = 0;
      return;
    end
    m_none = enable && (req == '0);
    if (!enable) begin
      m_owner = -1;
      return;
    end
    cand = req;
    if (m_owner >= 0) begin
      if (req[m_owner] &&
          !(rr_mode && m_cycles >= MAX_HOLD && (req & ~(4'b0001 << m_owner)) != '0)) begin
        m_cycles++;
        return;
      end
      cand[m_owner] = 1'b0;
    end
    w = pick(cand, rr_mode, m_ptr);
    m_owner  = w;
    m_cycles = (w >= 0) ? 1 : 0;
    if (w >= 0 && rr_mode) m_ptr = (w + N - 1) % N;
  endfunction

  task automatic check_all(input string tag);
    logic [N-1:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk({tag, ".gnt"},   32'(gnt),       32'(exp_gnt));
    chk({tag, ".idx"},   32'(gnt_idx),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
    chk({tag, ".none"},  32'(none),      32'(m_none));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; rr_mode = 1'b0; req = 4'b1111;

    // Reset held with all requests asserted
    step("reset0");
    step("reset1");
    chk("reset_gnt", 32'(gnt), 32'd0);
    rst_n = 1'b1;

    // Fixed priority, direct handover without an idle cycle
    req = 4'b0110;
    step("fixed_a");
    chk("fixed_a_gnt", 32'(gnt), 32'h4);
    chk("fixed_a_idx", 32'(gnt_idx), 32'd2);
    req = 4'b0011;
    step("fixed_b");
    chk("fixed_b_gnt", 32'(gnt), 32'h2);
    chk("fixed_b_idx", 32'(gnt_idx), 32'd1);

    // Idle / none flag
    req = 4'b0000;
    step("idle");
    chk("idle_none", 32'(none), 32'd1);

    // Round-robin: each winner drops its request after one cycle
    rr_mode = 1'b1;
    req = 4'b1111;
    step("rr0");
    chk("rr0_idx", 32'(gnt_idx), 32'd3);
    req = 4'b0111; step("rr1"); chk("rr1_idx", 32'(gnt_idx), 32'd2);
    req = 4'b1011; step("rr2"); chk("rr2_idx", 32'(gnt_idx), 32'd1);
    req = 4'b1101; step("rr3"); chk("rr3_idx", 32'(gnt_idx), 32'd0);
    req = 4'b1110; step("rr4"); chk("rr4_idx", 32'(gnt_idx), 32'd3);

    // Land the pointer on 3, then exercise the hold limit
    req = 4'b0001; step("rr_to0");
    req = 4'b0000; step("rr_idle");
    req = 4'b1001;
    for (int c = 0; c < 7; c++) begin
      step("hold");
      chk("hold_idx", 32'(gnt_idx), (c < 3 || c == 6) ? 32'd3 : 32'd0);
    end
    req = 4'b1000;
    for (int c = 0; c < 6; c++) begin
      step("lone");
      chk("lone_idx", 32'(gnt_idx), 32'd3);
    end

    // none with and without enable
    req = 4'b0000;
    step("none_en");
    chk("none_en_flag", 32'(none), 32'd1);
    chk("none_en_valid", 32'(gnt_valid), 32'd0);
    enable = 1'b0;
    step("none_dis");
    chk("none_dis_flag", 32'(none), 32'd0);

    // Enable dropped mid-grant, then re-enabled
    enable = 1'b1; req = 4'b0100;
    step("en_grant");
    chk("en_grant_idx", 32'(gnt_idx), 32'd2);
    enable = 1'b0;
    step("en_drop");
    chk("en_drop_gnt", 32'(gnt), 32'd0);
    enable = 1'b1;
    step("en_back");
    chk("en_back_idx", 32'(gnt_idx), 32'd2);

    // Asynchronous reset mid-grant, observed before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 32'd0);
    chk("async_valid", 32'(gnt_valid), 32'd0);
    chk("async_idx", 32'(gnt_idx), 32'd0);
    step("async_hold");
    rst_n = 1'b1;

    // Random traffic, with requests often held to reach the hold limit
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
